// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer RAM between display scan-out and a writer port
module vga_fb_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_display,
    input  logic              v_display,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              wr_oob
);
    localparam int XW = $clog2(FB_W << SCALE_SHIFT);
    localparam logic [XW-1:0]     X_MAX    = XW'((FB_W << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W:0]   FB_SIZE  = (ADDR_W+1)'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] ROW_MAX  = ADDR_W'((FB_H - 1) * FB_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t                 state;
    logic                   we_ok;
    logic                   disp;
    logic                   in_range;
    logic                   h_prev;
    logic                   v_prev;
    logic                   line_end;
    logic                   frame_end;
    logic [XW-1:0]          x;
    logic [SCALE_SHIFT-1:0] sub;
    logic [ADDR_W-1:0]      row_base;
    logic [2:0]             disp_pipe;
    logic [2:0]             hs_pipe;
    logic [2:0]             vs_pipe;

    assign disp        = h_display & v_display;
    assign wr_ready    = ~reset & ~disp;
    assign in_range    = {1'b0, wr_addr} < FB_SIZE;
    assign line_end    = h_prev & ~h_display & v_display;
    assign frame_end   = v_prev & ~v_display;
    assign mem_we      = (state == WRITE) & we_ok;
    assign pixel_valid = disp_pipe[2];
    assign h_sync_out  = hs_pipe[2];
    assign v_sync_out  = vs_pipe[2];

    // Access FSM: one RAM operation per cycle, display reads always win over the writer
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_ok     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_oob    <= 1'b0;
        end else begin
            state <= disp ? READ : wr_valid ? WRITE : IDLE;
            we_ok <= ~disp & wr_valid & in_range;
            if (disp)
                mem_addr <= row_base + ADDR_W'(x >> SCALE_SHIFT);
            else if (wr_valid) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
            if (~disp & wr_valid & ~in_range)
                wr_oob <= 1'b1;
        end
    end

    // Scan counters: column, sub-line and row base; frame end outranks line end
    always_ff @(posedge clk) begin
        if (reset) begin
            h_prev   <= 1'b0;
            v_prev   <= 1'b0;
            x        <= '0;
            sub      <= '0;
            row_base <= '0;
        end else begin
            h_prev <= h_display;
            v_prev <= v_display;
            if (frame_end) begin
                x        <= '0;
                sub      <= '0;
                row_base <= '0;
            end else if (line_end) begin
                x   <= '0;
                sub <= sub + 1'b1;
                if (&sub && row_base != ROW_MAX)
                    row_base <= row_base + ROW_STEP;
            end else if (disp && x != X_MAX)
                x <= x + 1'b1;
        end
    end

    // Output pipeline: window and syncs delayed to line up with the returned pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_pipe <= '0;
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            pixel     <= '0;
        end else begin
            disp_pipe <= {disp_pipe[1:0], disp};
            hs_pipe   <= {hs_pipe[1:0], h_sync_in};
            vs_pipe   <= {vs_pipe[1:0], v_sync_in};
            pixel     <= disp_pipe[1] ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed stimulus checked every cycle against a behavioural scan/arbitration model
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        h_display, v_display, h_sync_in, v_sync_in;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [5:0]  wr_data;
    logic        wr_ready;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [5:0]  mem_wdata;
    logic [5:0]  mem_rdata = '0;
    logic [5:0]  pixel;
    logic        pixel_valid, h_sync_out, v_sync_out, wr_oob;

    int vectors = 0;
    int misses  = 0;
    int cyc     = 0;
    int we_cnt  = 0;
    int last_rd = -1;
    int rd_log[$];
    logic held = 1'b0;

    logic rs[16384];
    logic ds[16384];
    logic hq[16384];
    logic vq[16384];
    int   ad[16384];

    int   col, line, row, c, e_addr, e_wdata;
    logic e_we, e_oob, ph, pv, d;
    int   e_pix;
    logic e_pv, e_hs, e_vs;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset),
        .h_display(h_display), .v_display(v_display),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel(pixel), .pixel_valid(pixel_valid),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .wr_oob(wr_oob)
    );

    always #20 clk = ~clk;

    function automatic logic [5:0] ram(input logic [14:0] a);
        return a[5:0] ^ a[11:6];
    endfunction

    // RAM stand-in: contents are a fixed function of the address, one cycle of read latency
    always @(posedge clk) mem_rdata <= ram(mem_addr);

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Model: scan position as plain line/column counts, arbitration by priority rules, pipeline by history
    always @(posedge clk) begin
        d = h_display & v_display;
        if (reset) begin
            e_addr = 0; e_we = 0; e_wdata = 0; e_oob = 0;
            col = 0; line = 0; ph = 0; pv = 0;
        end else begin
            e_we = 0;
            if (d) begin
                row = line >> 2;
                if (row > 119) row = 119;
                c = col > 639 ? 639 : col;
                e_addr = row * 160 + (c >> 2);
            end else if (wr_valid) begin
                e_addr  = int'(wr_addr);
                e_wdata = int'(wr_data);
                e_we    = wr_addr < 15'd19200;
                if (wr_addr >= 15'd19200) e_oob = 1;
            end
            if (pv && !v_display) begin col = 0; line = 0; end
            else if (ph && !h_display && v_display) begin col = 0; line++; end
            else if (d) col++;
            ph = h_display;
            pv = v_display;
        end
        rs[cyc] = reset; ds[cyc] = d; hq[cyc] = h_sync_in; vq[cyc] = v_sync_in; ad[cyc] = e_addr;
        if (cyc >= 2 && !rs[cyc] && !rs[cyc-1] && !rs[cyc-2]) begin
            e_pv  = ds[cyc-2];
            e_pix = ds[cyc-2] ? int'(ram(15'(ad[cyc-2]))) : 0;
            e_hs  = hq[cyc-2];
            e_vs  = vq[cyc-2];
        end else begin
            e_pv = 0; e_pix = 0; e_hs = 1; e_vs = 1;
        end
        #1;
        chk("wr_ready", int'(wr_ready), int'(!reset && !d));
        chk("mem_addr", int'(mem_addr), e_addr);
        chk("mem_we", int'(mem_we), int'(e_we));
        if (e_we) chk("mem_wdata", int'(mem_wdata), e_wdata);
        chk("pixel", int'(pixel), e_pix);
        chk("pixel_valid", int'(pixel_valid), int'(e_pv));
        chk("h_sync_out", int'(h_sync_out), int'(e_hs));
        chk("v_sync_out", int'(v_sync_out), int'(e_vs));
        chk("wr_oob", int'(wr_oob), int'(e_oob));
        if (mem_we) we_cnt++;
        if (!reset && d) begin
            rd_log.push_back(int'(mem_addr));
            last_rd = int'(mem_addr);
        end
        cyc++;
    end

    task automatic drop_held();
        if (held && wr_valid && wr_ready) begin
            wr_valid = 0;
            held = 0;
        end
    endtask

    task automatic scan_line(input int act, input int blk, input int nb, input int base,
                             input logic [5:0] dat, input logic hold_w);
        for (int i = 0; i < act; i++) begin
            @(negedge clk);
            drop_held();
            if (i == 0 && hold_w) begin
                wr_valid = 1; wr_addr = 15'd500; wr_data = 6'h3F; held = 1;
            end
            h_display = 1; v_display = 1; h_sync_in = 1;
        end
        for (int i = 0; i < blk; i++) begin
            @(negedge clk);
            drop_held();
            h_display = 0; v_display = 1;
            h_sync_in = !(i >= blk / 8 && i < blk / 2);
            if (!held) begin
                wr_valid = i < nb; wr_addr = 15'(base + i); wr_data = dat;
            end
        end
    endtask

    task automatic vgap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h_display = 0; v_display = 0; h_sync_in = 1; wr_valid = 0;
            v_sync_in = !(i >= 1 && i < 3);
        end
    endtask

    initial begin
        reset = 1; h_display = 0; v_display = 0; h_sync_in = 1; v_sync_in = 1;
        wr_valid = 0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_pixel_valid", int'(pixel_valid), 0);
        chk("rst_h_sync_out", int'(h_sync_out), 1);
        chk("rst_wr_oob", int'(wr_oob), 0);
        reset = 0;
        #1 chk("wr_ready_after_rst", int'(wr_ready), 1);
        repeat (2) @(negedge clk);
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_valid = 1; wr_addr = 15'(100 + i); wr_data = 6'h2A;
        end
        @(negedge clk) wr_valid = 0;
        @(negedge clk);
        chk("stream_beats", we_cnt, 10);
        @(negedge clk) begin wr_valid = 1; wr_addr = 15'd19200; wr_data = 6'h01; end
        @(negedge clk) wr_valid = 0;
        @(negedge clk);
        chk("oob_set", int'(wr_oob), 1);
        chk("oob_no_we", we_cnt, 10);
        vgap(4);
        scan_line(0, 5, 0, 0, 6'h00, 0);
        scan_line(640, 160, 0, 0, 6'h00, 0);
        scan_line(640, 160, 5, 200, 6'h11, 0);
        scan_line(640, 160, 0, 0, 6'h00, 1);
        scan_line(640, 160, 0, 0, 6'h00, 0);
        scan_line(640, 160, 0, 0, 6'h00, 0);
        vgap(6);
        chk("rd_first", rd_log[0], 0);
        chk("rd_x3", rd_log[3], 0);
        chk("rd_x4", rd_log[4], 1);
        chk("rd_line_end", rd_log[639], 159);
        chk("rd_line4_start", rd_log[640 * 3], 0);
        chk("rd_line5_start", rd_log[640 * 4], 160);
        chk("rd_line5_end", rd_log[640 * 4 + 639], 319);
        chk("oob_sticky", int'(wr_oob), 1);
        scan_line(650, 20, 0, 0, 6'h00, 0);
        scan_line(8, 4, 0, 0, 6'h00, 0);
        vgap(4);
        chk("rd_frame2_start", rd_log[3200], 0);
        chk("rd_x_saturated", rd_log[3200 + 649], 159);
        for (int l = 0; l < 490; l++) scan_line(2, 2, 0, 0, 6'h00, 0);
        vgap(4);
        chk("rd_row_saturated", last_rd, 19040);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid = 1; wr_addr = 15'(300 + i); wr_data = 6'h15;
            reset = (i == 3 || i == 4);
        end
        @(negedge clk) wr_valid = 0;
        repeat (4) @(negedge clk);
        chk("oob_cleared", int'(wr_oob), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
